// File: rtl/uart_tx_responder.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO behind TXDATA, status at BASE_ADDR+4.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wd,
    output logic [31:0] mem_rd,
    output logic        hit,
    output logic        tx,
    output logic        busy
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, state_n;
    logic [CW-1:0]   clk_cnt, clk_n;
    logic [2:0]      bit_cnt, bit_n;
    logic [7:0]      shift, shift_n;
    logic            tx_n;
`ifdef UART_TX_PARITY_EN
    logic            par, par_n;
`endif

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic [CNTW-1:0] count;
    logic            ovf, full, empty, push, pop, drop, stat_we, bit_end;
    logic            unused_wd;

    assign unused_wd = ^mem_wd[31:8];

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign busy    = !empty || (state != IDLE);
    assign hit     = (mem_addr == BASE_ADDR) || (mem_addr == BASE_ADDR + 32'd4);
    assign stat_we = mem_we && (mem_addr == BASE_ADDR + 32'd4);
    assign push    = mem_we && (mem_addr == BASE_ADDR) && !full;
    assign drop    = mem_we && (mem_addr == BASE_ADDR) && full;
    assign mem_rd  = (mem_addr == BASE_ADDR + 32'd4) ? {29'b0, ovf, full, busy} : 32'b0;
    assign bit_end = (clk_cnt == CLK_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: ;
            endcase
            // a drop in the same cycle as a status write wins
            if (drop)         ovf <= 1'b1;
            else if (stat_we) ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr] <= mem_wd[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            clk_cnt <= clk_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            tx      <= tx_n;
`ifdef UART_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        clk_n   = bit_end ? '0 : clk_cnt + CW'(1);
        bit_n   = bit_cnt;
        shift_n = shift;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        case (state)
            IDLE: begin
                clk_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                    bit_n   = '0;
                    shift_n = fifo_mem[rptr];
`ifdef UART_TX_PARITY_EN
                    par_n   = ^fifo_mem[rptr];
`endif
                end
            end
            START: if (bit_end) state_n = DATA;
            DATA: begin
                if (bit_end) begin
                    shift_n = shift >> 1;
                    bit_n   = bit_cnt + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_cnt == 3'd7) state_n = PARITY;
`else
                    if (bit_cnt == 3'd7) state_n = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_n = STOP;
`endif
            STOP: begin
                // chain straight into the next START so streamed frames have no gap
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = START;
                        bit_n   = '0;
                        shift_n = fifo_mem[rptr];
`ifdef UART_TX_PARITY_EN
                        par_n   = ^fifo_mem[rptr];
`endif
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is computed from the next state so the output flop is the only driver
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_responder.sv
// Directed bench for uart_tx_responder: reset, single frame, overflow, streaming,
// mid-frame reset and (with UART_TX_PARITY_EN) parity frames.
module tb_uart_tx_responder;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        hit;
    logic        tx;
    logic        busy;

    int nchk = 0;
    int nerr = 0;

    uart_tx_responder dut (
        .clk(clk), .rst(rst), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd), .hit(hit), .tx(tx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        mem_we   = 1'b1;
        mem_addr = addr;
        mem_wd   = data;
        step();
        mem_we   = 1'b0;
    endtask

    // checks tx for every cycle of one frame, starting at the current sample point
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [NB-1:0] fr;
`ifdef UART_TX_PARITY_EN
        fr = {1'b1, ^b, b, 1'b0};
`else
        fr = {1'b1, b, 1'b0};
`endif
        for (int c = 0; c < NB * CPB; c++) begin
            chk($sformatf("%s_c%0d", tag, c), {31'b0, tx}, {31'b0, fr[c / CPB]});
            step();
        end
    endtask

    initial begin
        int n;
        int lows;
        rst = 1'b0; mem_we = 1'b0; mem_addr = 32'h1004; mem_wd = '0;

        // reset state
        repeat (3) step();
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_status", mem_rd, 32'd0);
        rst = 1'b1;
        step();
        chk("idle_status", mem_rd, 32'd0);
        chk("hit_status", {31'b0, hit}, 32'd1);
        mem_addr = 32'h1000;
        #1;
        chk("rd_txdata", mem_rd, 32'd0);
        chk("hit_txdata", {31'b0, hit}, 32'd1);
        mem_addr = 32'h1008;
        #1;
        chk("hit_other", {31'b0, hit}, 32'd0);

        // single byte: tx stays high on the push edge, falls one edge later
        store(32'h1000, 32'hFFFF_FF55);
        chk("sb_tx_push", {31'b0, tx}, 32'd1);
        chk("sb_busy_push", {31'b0, busy}, 32'd1);
        step();
        check_frame(8'h55, "sb");
        chk("sb_busy_end", {31'b0, busy}, 32'd0);
        chk("sb_tx_end", {31'b0, tx}, 32'd1);

        // overflow: 6 consecutive stores, one pop after the first
        for (int i = 0; i < 6; i++) begin
            mem_we = 1'b1; mem_addr = 32'h1000; mem_wd = 32'(8'h10 + i);
            step();
        end
        mem_we = 1'b0; mem_addr = 32'h1004;
        #1;
        chk("ovf_status", mem_rd, 32'h7);
        store(32'h1004, 32'hFFFF_FFFF);
        chk("ovf_clear", mem_rd, 32'h3);
        n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
        chk("ovf_drain_cycles", n, 32'd195);
        chk("ovf_drain_status", mem_rd, 32'h0);

        // streaming: two frames with no idle gap
        store(32'h1000, 32'hA0);
        store(32'h1000, 32'h0F);
        check_frame(8'hA0, "st0");
        check_frame(8'h0F, "st1");
        chk("st_busy_end", {31'b0, busy}, 32'd0);
        chk("st_tx_end", {31'b0, tx}, 32'd1);

        // reset during DATA bit 3 with a second byte queued
        store(32'h1000, 32'h5A);
        store(32'h1000, 32'h3C);
        repeat (17) step();
        chk("mr_bit3", {31'b0, tx}, 32'd1);
        chk("mr_busy_pre", {31'b0, busy}, 32'd1);
        rst = 1'b0;
        step();
        chk("mr_tx", {31'b0, tx}, 32'd1);
        chk("mr_busy", {31'b0, busy}, 32'd0);
        rst = 1'b1; mem_addr = 32'h1004;
        step();
        chk("mr_status", mem_rd, 32'd0);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
            step();
        end
        chk("mr_quiet", lows, 32'd0);

`ifdef UART_TX_PARITY_EN
        store(32'h1000, 32'h07);
        step();
        check_frame(8'h07, "p07");
        chk("p07_busy_end", {31'b0, busy}, 32'd0);
        store(32'h1000, 32'h03);
        step();
        check_frame(8'h03, "p03");
        chk("p03_busy_end", {31'b0, busy}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/uart_tx_responder.md
# uart_tx_responder

Memory-mapped UART transmitter that responds to the single-cycle core's data-memory store/load interface. The core is the initiator: it stores bytes to a TXDATA address and polls a STATUS address. This block is the responder. It buffers stored bytes in a small FIFO and serialises them onto a `tx` line (8N1, LSB first). It sits beside data memory in `Single_Cycle_Top`, selected by address decode, and gives benches a visible serial output from running programs.

## Interface
- `BASE_ADDR`, default 32'h0000_1000: TXDATA word address; STATUS is at BASE_ADDR+4.
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, default 4: byte FIFO entries; must be a power of 2, ≥2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `mem_we`  in  1  store strobe from the core.
- `mem_addr`  in  32  byte address from the core.
- `mem_wd`  in  32  store data; only bits [7:0] are used.
- `mem_rd`  out  32  combinational read data.
- `hit`  out  1  combinational; high when `mem_addr` equals BASE_ADDR or BASE_ADDR+4.
- `tx`  out  1  serial output; idles high.
- `busy`  out  1  high when the FIFO is non-empty or the FSM is not IDLE.

## Operation
- **TXDATA write.** Condition: `mem_we` && `mem_addr`==BASE_ADDR.
  - If the FIFO is not full (count sampled before the edge), push `mem_wd[7:0]`.
  - Otherwise drop the byte and set the sticky `ovf` flag.
- **STATUS write.** Condition: `mem_we` && `mem_addr`==BASE_ADDR+4. Clears `ovf` and ignores data. If an overflow occurs in the same cycle, set takes priority.
- **Reads.**
  - `mem_rd` = {29'b0, ovf, full, busy} when `mem_addr`==BASE_ADDR+4.
  - `mem_rd` = 0 for any other address, including TXDATA.
- **FIFO.**
  - Circular; read and write pointers wrap modulo FIFO_DEPTH.
  - Count width is log2(FIFO_DEPTH)+1, so full and empty are distinct.
  - A push and a pop in the same cycle are both performed and leave the count unchanged.
- **FSM states:** IDLE, START, DATA, [PARITY], STOP.
  - IDLE, FIFO non-empty: pop the head into an 8-bit shift register, go to START, reset the bit counter.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx`=shift[0]; shift right every CLKS_PER_BIT cycles; after 8 bits go to PARITY if enabled, otherwise STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. Then go to START with an immediate pop if the FIFO is non-empty, otherwise go to IDLE.
- `tx` is registered and glitch-free.
- **Reset** (while `rst`==0 at an edge):
  - FSM goes to IDLE; pointers, count, `ovf` and counters clear.
  - `tx`=1, `busy`=0.
  - `mem_rd`/`hit` remain combinational.
  - Reset mid-frame aborts the frame: `tx` is high after that edge and FIFO contents are discarded.

## Timing
- A store at edge N makes the byte visible in the FIFO after edge N.
- The FSM pops at edge N+1; `tx` falls after edge N+1.
- Frame length: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- Back-to-back frames: no idle gap; the START of the next frame follows the last STOP cycle directly.
- `busy` rises after the push edge. It falls after the final STOP edge when the FIFO is empty.
- `full` and `busy` reflect registered state; STATUS reads have zero-cycle latency.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state inserted after DATA; `tx`=^byte (even parity) for CLKS_PER_BIT cycles; frame is 11 bit-times.
- Not defined: no PARITY state; 8N1 framing, 10 bit-times.

## Test plan
All scenarios use the defaults (CLKS_PER_BIT=4, FIFO_DEPTH=4) with parity disabled unless stated.
- **Reset state.** Hold `rst`=0 for 3 cycles, then read STATUS → `tx`=1, `busy`=0, `mem_rd`=0.
- **Single byte.** Store 0x55 to 0x1000 → `tx` goes low 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles. `busy` falls 41 cycles after the store edge.
- **Overflow.** Store 6 bytes on consecutive cycles → first 5 are accepted (one is popped after the first store). Sixth is dropped. STATUS reads 0x7 (ovf, full, busy). A store to 0x1004 then reads 0x3.
- **Streaming.** Store 0xA0, 0x0F back-to-back → two frames with no gap; 80 cycles total from first `tx` fall to final idle.
- **Reset mid-frame.** Assert `rst`=0 during DATA bit 3 with 2 bytes queued → `tx`=1 after that edge; STATUS reads 0 after release; no further frames.
- **Parity build.** With `UART_TX_PARITY_EN`, store 0x07 → parity bit 1; frame is 44 cycles. Store 0x03 → parity bit 0.
